// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// holds each fetched instruction for decode until it is consumed or squashed.
module ifetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [31:0]         imem_resp_data,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [31:0]         id_instr,
    output logic [5:0]          id_opcode,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [PC_WIDTH-1:0] id_pc_plus4,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_drop;
    logic [31:0]         r_id_instr;
    logic [PC_WIDTH-1:0] r_id_pc;

    state_t              w_state_nxt;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic                w_drop_nxt;
    logic                w_capture;
    logic [PC_WIDTH-1:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc & ~PC_WIDTH'(3);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_id_instr <= '0;
            r_id_pc    <= '0;
        end else begin
            r_pc   <= w_pc_nxt;
            r_drop <= w_drop_nxt;
            if (w_capture) begin
                r_id_instr <= imem_resp_data;
                r_id_pc    <= r_pc;
            end
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                    w_drop_nxt  = redirect_valid;
                end
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    w_drop_nxt = 1'b0;
                    if (redirect_valid) begin
                        w_state_nxt = S_REQ;
                        w_pc_nxt    = w_redirect_pc;
                    end else if (r_drop) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_capture   = 1'b1;
                        w_pc_nxt    = r_pc + PC_WIDTH'(4);
                    end
                end else if (redirect_valid) begin
                    w_drop_nxt = 1'b1;
                    w_pc_nxt   = w_redirect_pc;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_state_nxt = S_REQ;
                    w_pc_nxt    = w_redirect_pc;
                end else if (id_ready) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req_valid = (r_state == S_REQ);
        id_valid       = (r_state == S_HOLD);
    end

    assign imem_req_addr = r_pc;
    assign id_instr      = r_id_instr;
    assign id_opcode     = r_id_instr[31:26];
    assign id_pc         = r_id_pc;
    assign id_pc_plus4   = r_id_pc + PC_WIDTH'(4);

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios then random traffic,
// compared each cycle against a transaction-level fetch model.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    ifetch_unit #(.PC_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_opcode       (id_opcode),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: next fetch address, one outstanding fetch,
    // one instruction held for decode.
    logic        m_known = 1'b0;
    logic        m_rst_chk = 1'b0;
    logic        m_idle = 1'b0;
    logic [31:0] m_pc = '0;
    logic        m_out = 1'b0;
    logic        m_out_kill = 1'b0;
    logic [31:0] m_out_addr = '0;
    int          m_wait = 0;
    logic        m_hold = 1'b0;
    logic [31:0] m_hold_addr = '0;
    logic [31:0] m_hold_data = '0;

    int          g_min_delay = 0;
    int          g_max_delay = 0;
    logic        g_use_fixed = 1'b0;
    logic [31:0] g_fixed = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic rrdy, input logic idr,
                         input logic rv, input logic [31:0] rpc, input logic stray);
        logic        exp_rv;
        logic        hs;
        logic        rd;
        logic        resp;
        logic        resp_drv;
        logic        old_hold;
        logic [31:0] data;
        @(negedge clk);
        exp_rv = m_known && !m_idle && !m_out && !m_hold;
        if (m_known) begin
            check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (exp_rv) check("req_addr", imem_req_addr, m_pc);
            check("id_valid", 32'(id_valid), 32'(m_hold));
            if (m_hold) begin
                check("id_pc", id_pc, m_hold_addr);
                check("id_instr", id_instr, m_hold_data);
                check("id_opcode", 32'(id_opcode), 32'(m_hold_data[31:26]));
                check("id_pc_plus4", id_pc_plus4, m_hold_addr + 32'd4);
            end
            if (m_rst_chk) begin
                check("rst_id_instr", id_instr, 32'h0);
                check("rst_id_pc", id_pc, 32'h0);
                check("rst_id_pc_plus4", id_pc_plus4, 32'h4);
                check("rst_req_addr", imem_req_addr, RESET_PC);
            end
        end

        data = g_use_fixed ? g_fixed : $urandom;
        resp_drv = 1'b0;
        if (m_out && m_wait == 0) resp_drv = 1'b1;
        else if (stray && !m_out) resp_drv = 1'b1;
        rst_n           = rst;
        imem_req_ready  = rrdy;
        id_ready        = idr;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_resp_valid = resp_drv;
        imem_resp_data  = data;

        if (!rst) begin
            m_known   = 1'b1;
            m_rst_chk = 1'b1;
            m_idle    = 1'b1;
            m_pc      = RESET_PC;
            m_out     = 1'b0;
            m_hold    = 1'b0;
            m_wait    = 0;
        end else if (m_known) begin
            m_rst_chk = 1'b0;
            hs   = exp_rv && rrdy;
            rd   = rv && !m_idle;
            resp = resp_drv && m_out;
            if (m_idle) begin
                m_idle = 1'b0;
            end else begin
                old_hold = m_hold;
                if (old_hold && (idr || rd)) m_hold = 1'b0;
                if (m_out && !resp) m_wait--;
                if (resp) begin
                    m_out = 1'b0;
                    if (!m_out_kill && !rd) begin
                        m_hold      = 1'b1;
                        m_hold_addr = m_out_addr;
                        m_hold_data = data;
                        m_pc        = m_out_addr + 32'd4;
                    end
                end
                if (hs) begin
                    m_out      = 1'b1;
                    m_out_kill = 1'b0;
                    m_out_addr = m_pc;
                    m_wait     = $urandom_range(g_max_delay, g_min_delay);
                end
                if (rd) begin
                    m_pc = {rpc[31:2], 2'b00};
                    if (m_out) m_out_kill = 1'b1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic run_ready(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic until_out;
        for (int k = 0; k < 20 && !m_out; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        // Reset, then zero-wait streaming at 0x0, 0x4, 0x8.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_ready(10);

        // lw held while decode stalls for five cycles.
        g_use_fixed = 1'b1;
        g_fixed     = 32'h8C01_0004;
        for (int k = 0; k < 20 && !m_hold; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        g_use_fixed = 1'b0;
        run_ready(2);

        // Memory back-pressure: request stays up with a stable address.
        for (int k = 0; k < 20 && m_out; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        run_ready(4);

        // Redirect to 0x40 while waiting on a slow response.
        g_min_delay = 2;
        g_max_delay = 2;
        until_out();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
        run_ready(8);

        // Redirect to unaligned 0x103 while holding with decode ready.
        g_min_delay = 0;
        g_max_delay = 0;
        for (int k = 0; k < 20 && !m_hold; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        run_ready(4);

        // Redirect coincident with the response.
        until_out();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        run_ready(6);

        // Reset mid-WAIT followed by a stray response.
        g_min_delay = 2;
        g_max_delay = 2;
        until_out();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        run_ready(6);

        // PC wrap at the top of the address space.
        g_min_delay = 0;
        g_max_delay = 0;
        for (int k = 0; k < 20 && !(m_out == 1'b0 && m_hold == 1'b0); k++)
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run_ready(9);

        // Random traffic.
        g_max_delay = 3;
        for (int k = 0; k < 3000; k++) begin
            logic        r_rst;
            logic        r_rv;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(99, 0) < 1) ? 1'b0 : 1'b1;
            r_rv  = ($urandom_range(99, 0) < 10);
            r_pc  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                 : $urandom;
            cycle(r_rst, $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60,
                  r_rv, r_pc, $urandom_range(99, 0) < 10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of control_unit. It holds the program counter and issues word fetches to instruction memory over a valid/ready request and valid response interface. It presents each fetched instruction, its opcode field and its PC to decode over a valid/ready handshake. A redirect input from branch resolution (control_unit branch_en qualified by ALU result) retargets the PC and squashes any in-flight or held fetch.

Parameters:
PC_WIDTH, 32, width of PC and all address ports
RESET_PC, 32'h0000_0000, PC loaded at reset; must be word-aligned

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  instruction memory accepts request
imem_req_addr  output  PC_WIDTH  fetch byte address, bits [1:0] always 0
imem_resp_valid  input  1  response data valid, one cycle per accepted request
imem_resp_data  input  32  fetched instruction word
id_valid  output  1  instruction available to decode
id_ready  input  1  decode consumes instruction
id_instr  output  32  held instruction word
id_opcode  output  6  id_instr[31:26], feeds control_unit opcode
id_pc  output  PC_WIDTH  address of id_instr
id_pc_plus4  output  PC_WIDTH  id_pc + 4, modulo 2^PC_WIDTH
redirect_valid  input  1  branch/jump taken, one-cycle pulse or level
redirect_pc  input  PC_WIDTH  new fetch target; bits [1:0] ignored and forced to 0

Behaviour:
- Registers: pc, state, drop flag, id_instr, id_pc. All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Reset (rst_n low at a clock edge, any state): state=IDLE, pc=RESET_PC, drop=0, id_valid=0, imem_req_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4. Reset mid-transaction abandons the fetch. A response arriving after reset while not in WAIT is ignored.
- imem_req_valid=1 only in REQ. imem_req_addr=pc. id_valid=1 only in HOLD.
- IDLE: go to REQ next cycle unconditionally.
- REQ: on imem_req_valid&imem_req_ready, go to WAIT. Only one request is ever outstanding. The address stays stable while the request is unaccepted.
- WAIT: ignore everything until imem_resp_valid.
  - If drop=1: discard data, clear drop, go to REQ. pc already holds the redirect target.
  - Else: capture id_instr=imem_resp_data and id_pc=pc, set pc=pc+4 (wraps at 2^PC_WIDTH), go to HOLD.
- HOLD: id_instr, id_pc and id_pc_plus4 are held stable while id_ready=0. On id_ready=1, go to REQ. id_valid is low the next cycle.
- imem_resp_valid outside WAIT is ignored.
- Latency: request accepted at edge T gives a response at T+1 at the earliest. id_valid is high from T+2. Back-to-back throughput is one instruction per 3 cycles with a zero-wait memory and id_ready held high.
- Redirect has priority over every other transition in every non-IDLE state. On redirect_valid: pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}.
  - REQ with no handshake in the same cycle: stay in REQ, new address next cycle.
  - REQ with handshake in the same cycle: go to WAIT with drop=1.
  - WAIT with no response in the same cycle: stay in WAIT, drop=1.
  - WAIT with a response in the same cycle: discard the response, go to REQ, drop=0.
  - HOLD: squash the held instruction (id_valid low next cycle, even if id_ready was high this cycle), go to REQ.
  - IDLE: redirect is ignored; reset PC wins.
- Consecutive redirects: the last one wins. At most one response is dropped per outstanding request.

Test Plan:
- Reset with RESET_PC=0 and zero-wait memory returning addr-derived words, id_ready=1 → imem_req_addr sequence 0x0,0x4,0x8; id_instr/id_pc pairs match; id_opcode=id_instr[31:26]; id_valid pulses 1 cycle in every 3.
- Hold id_ready=0 for 5 cycles while id_valid=1 (instr 0x8C010004, lw) → id_instr, id_pc and id_opcode=6'b100011 stable; imem_req_valid stays 0. Release → next request at id_pc+4.
- imem_req_ready low 4 cycles → imem_req_valid and addr 0x8 stable; accepted on the 5th cycle.
- Redirect to 0x40 while in WAIT for 0xC, response 2 cycles later → that response is not presented. Next request address is 0x40; id_pc=0x40.
- Redirect to 0x103 while in HOLD with id_ready=1 → held instruction not consumed, next imem_req_addr=0x100. Redirect in the same cycle as a response → response dropped, next request at the target.
- Assert rst_n=0 for one cycle during WAIT → all outputs at reset values. A stray response 1 cycle later is ignored. The first request after IDLE is at RESET_PC.
